conv_encoder: RTL and testbench

- Rate-1/2 feed-forward convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder datapath (branch metric, add-compare-select, traceback).
- Accepts a framed serial bit stream and emits one 2-bit code symbol per input bit.
- Terminates every frame with K-1 zero tail bits, so the decoder's traceback starts from state 0.
- Shift-register state numbering is identical to the decoder trellis state index.

---
 rtl/conv_encoder_if.sv | 22 ++
 rtl/conv_encoder.sv | 155 +++++++++++++++
 tb/tb_conv_encoder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_encoder_if.sv
// Stream interface for conv_encoder: serial input bits in, 2-bit code symbols out.
interface conv_encoder_if;
    logic       i_valid;
    logic       o_ready;
    logic       i_bit;
    logic       i_last;
    logic       o_valid;
    logic       i_ready;
    logic [1:0] o_sym;
    logic [1:0] o_sym_mask;
    logic       o_last;

    modport master (
        input  i_valid, i_bit, i_last, i_ready,
        output o_ready, o_valid, o_sym, o_sym_mask, o_last
    );

    modport slave (
        output i_valid, i_bit, i_last, i_ready,
        input  o_ready, o_valid, o_sym, o_sym_mask, o_last
    );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with K-1 zero-tail frame termination.
// Optional rate-2/3 puncturing ([11;10]) when CONV_ENC_PUNCT_EN is defined.
module conv_encoder #(
    parameter int unsigned     K      = 3,
    parameter logic [K-1:0]    G0     = 3'b111,
    parameter logic [K-1:0]    G1     = 3'b101,
    parameter int unsigned     FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    conv_encoder_if.master    bus,
    output logic              o_busy,
    output logic [FCNT_W-1:0] o_frame_cnt
);
    localparam int unsigned TW = $clog2(K);

    typedef enum logic [1:0] {S_DATA, S_TAIL, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [K-2:0]      sr_q, sr_d;
    logic [TW-1:0]     tail_q, tail_d;
    logic              valid_q, valid_d;
    logic [1:0]        sym_q, sym_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d;
    logic              ready_c;
    logic              slot_free;
    logic              load;
    logic              d;
    logic              tail_end;
    logic [K-1:0]      w;
`ifdef CONV_ENC_PUNCT_EN
    logic              phase_q, phase_d;
    logic [1:0]        mask_q, mask_d;
`endif

    assign slot_free = ~valid_q | bus.i_ready;

    // Next-state, encode and output-register load
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        tail_d   = tail_q;
        valid_d  = valid_q & ~bus.i_ready;
        sym_d    = sym_q;
        last_d   = last_q & ~(valid_q & bus.i_ready);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        ready_c  = 1'b0;
        load     = 1'b0;
        d        = 1'b0;
        tail_end = 1'b0;
        w        = '0;
`ifdef CONV_ENC_PUNCT_EN
        phase_d  = phase_q;
        mask_d   = mask_q;
`endif

        case (state_q)
            S_DATA: begin
                ready_c = slot_free & ~rst;
                if (bus.i_valid && slot_free) begin
                    load   = 1'b1;
                    d      = bus.i_bit;
                    busy_d = 1'b1;
                    if (bus.i_last) begin
                        state_d = S_TAIL;
                        tail_d  = TW'(K - 1);
                    end
                end
            end
            S_TAIL: begin
                if (slot_free) begin
                    load   = 1'b1;
                    tail_d = tail_q - TW'(1);
                    if (tail_q == TW'(1)) begin
                        tail_end = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Frame closes only when the o_last symbol leaves the register
                if (valid_q && last_q && bus.i_ready) begin
                    sr_d    = '0;
                    cnt_d   = cnt_q + FCNT_W'(1);
                    busy_d  = 1'b0;
                    state_d = S_DATA;
`ifdef CONV_ENC_PUNCT_EN
                    phase_d = 1'b0;
`endif
                end
            end
            default: state_d = S_DATA;
        endcase

        if (load) begin
            w       = {sr_q, d};
            sym_d   = {^(w & G0), ^(w & G1)};
            valid_d = 1'b1;
            last_d  = tail_end;
            sr_d    = {sr_q[K-3:0], d};
`ifdef CONV_ENC_PUNCT_EN
            mask_d  = phase_q ? 2'b10 : 2'b11;
            if (phase_q) begin
                sym_d[0] = 1'b0;
            end
            phase_d = ~phase_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_DATA;
            sr_q    <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
            sym_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef CONV_ENC_PUNCT_EN
            phase_q <= 1'b0;
            mask_q  <= 2'b11;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            sym_q   <= sym_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
`ifdef CONV_ENC_PUNCT_EN
            phase_q <= phase_d;
            mask_q  <= mask_d;
`endif
        end
    end

    assign bus.o_ready    = ready_c;
    assign bus.o_valid    = valid_q;
    assign bus.o_sym      = sym_q;
    assign bus.o_last     = last_q;
`ifdef CONV_ENC_PUNCT_EN
    assign bus.o_sym_mask = mask_q;
`else
    assign bus.o_sym_mask = 2'b11;
`endif
    assign o_busy         = busy_q;
    assign o_frame_cnt    = cnt_q;
endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed frame table, reset mid-frame, random frames vs reference model.
module tb_conv_encoder;
    localparam int unsigned K = 3;
    localparam logic [2:0] G0_T = 3'b111;
    localparam logic [2:0] G1_T = 3'b101;

    typedef struct {
        logic [15:0] bits;
        int          n;
        int          mode;
        int          nsym;
        logic [1:0]  syms [8];
    } vec_t;

    typedef struct packed {
        logic [1:0] sym;
        logic [1:0] mask;
        logic       last;
    } rx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, busy_w;
    logic [15:0] cnt;
    logic [1:0]  cnt_w;

    int          total = 0;
    int          bad = 0;
    int          ready_mode = 0;
    int          cyc = 0;
    int          exp_cnt = 0;
    rx_t         got[$];
    logic [1:0]  exp_q[$];
    logic        seen_last = 1'b0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [1:0]  ps = 2'b00, pm = 2'b00;
    vec_t        tbl [6];

    conv_encoder_if bus ();
    conv_encoder_if bus_w ();

    assign bus_w.i_valid = bus.i_valid;
    assign bus_w.i_bit   = bus.i_bit;
    assign bus_w.i_last  = bus.i_last;
    assign bus_w.i_ready = bus.i_ready;

    conv_encoder dut (
        .clk(clk), .rst(rst), .bus(bus), .o_busy(busy), .o_frame_cnt(cnt)
    );

    conv_encoder #(.FCNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w), .o_busy(busy_w), .o_frame_cnt(cnt_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Downstream ready pattern: 0 always ready, 1 = 1,0,0,1 cycle, 2 = random
    always @(posedge clk) begin
        #1;
        cyc <= cyc + 1;
        case (ready_mode)
            1:       bus.i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       bus.i_ready = ($urandom_range(0, 3) != 0);
            default: bus.i_ready = 1'b1;
        endcase
    end

    // Symbol collector plus stall-hold checks
    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", bus.o_valid, 1);
                chk("hold_sym", bus.o_sym, ps);
                chk("hold_mask", bus.o_sym_mask, pm);
                chk("hold_last", bus.o_last, pl);
            end
            if (bus.o_valid && !bus.i_ready) chk("ready_in_stall", bus.o_ready, 0);
            if (bus.o_valid && bus.i_ready) begin
                got.push_back('{sym: bus.o_sym, mask: bus.o_sym_mask, last: bus.o_last});
                if (bus.o_last) seen_last <= 1'b1;
            end
            pv <= bus.o_valid;
            pr <= bus.i_ready;
            ps <= bus.o_sym;
            pm <= bus.o_sym_mask;
            pl <= bus.o_last;
        end
    end

    // Reference: symbol j is the XOR-convolution of the zero-padded bit stream with each generator
    function automatic logic [1:0] model_sym(input logic [15:0] bits, input int n, input int j);
        logic g0 = 1'b0;
        logic g1 = 1'b0;
        for (int i = 0; i < int'(K); i++) begin
            int idx = j - i;
            if (idx >= 0 && idx < n) begin
                g0 ^= G0_T[i] & bits[idx];
                g1 ^= G1_T[i] & bits[idx];
            end
        end
        return {g0, g1};
    endfunction

    function automatic logic [1:0] exp_mask(input int j);
`ifdef CONV_ENC_PUNCT_EN
        return (j % 2 == 1) ? 2'b10 : 2'b11;
`else
        return (j >= 0) ? 2'b11 : 2'b11;
`endif
    endfunction

    task automatic send_frame(input logic [15:0] bits, input int n);
        got.delete();
        seen_last <= 1'b0;
        for (int k = 0; k < n; k++) begin
            bit done = 1'b0;
            bus.i_valid = 1'b1;
            bus.i_bit   = bits[k];
            bus.i_last  = (k == n - 1);
            for (int t = 0; t < 500 && !done; t++) begin
                @(negedge clk);
                if (bus.o_ready) begin
                    @(posedge clk);
                    #1;
                    done = 1'b1;
                end
            end
            if (!done) chk("accept_timeout", 0, 1);
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic finish_frame(input string nm);
        bit done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(posedge clk);
            #1;
            if (seen_last) done = 1'b1;
        end
        if (!done) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_len"}, got.size(), exp_q.size());
        for (int j = 0; j < got.size() && j < exp_q.size(); j++) begin
            logic [1:0] es = exp_q[j];
            if (exp_mask(j) == 2'b10) es[0] = 1'b0;
            chk({nm, "_sym"}, got[j].sym, es);
            chk({nm, "_mask"}, got[j].mask, exp_mask(j));
            chk({nm, "_last"}, got[j].last, (j == exp_q.size() - 1));
        end
        exp_cnt++;
        chk({nm, "_cnt"}, cnt, exp_cnt % 65536);
        chk({nm, "_cnt_w2"}, cnt_w, exp_cnt % 4);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_valid_idle"}, bus.o_valid, 0);
    endtask

    initial begin
        tbl[0] = '{bits: 16'b1101, n: 4, mode: 0, nsym: 6,
                   syms: '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00}};
        tbl[1] = '{bits: 16'b1101, n: 4, mode: 1, nsym: 6,
                   syms: '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00}};
        tbl[2] = '{bits: 16'b1, n: 1, mode: 0, nsym: 3,
                   syms: '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}};
        tbl[3] = '{bits: 16'b1, n: 1, mode: 0, nsym: 3,
                   syms: '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}};
        tbl[4] = '{bits: 16'b0, n: 1, mode: 0, nsym: 3,
                   syms: '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}};
        tbl[5] = '{bits: 16'b11, n: 2, mode: 2, nsym: 4,
                   syms: '{2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00}};

        bus.i_valid = 1'b0;
        bus.i_bit   = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", bus.o_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_sym", bus.o_sym, 0);
        chk("rst_mask", bus.o_sym_mask, 2'b11);
        chk("rst_last", bus.o_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ready", bus.o_ready, 1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            ready_mode = tbl[v].mode;
            exp_q.delete();
            for (int j = 0; j < tbl[v].nsym; j++) exp_q.push_back(tbl[v].syms[j]);
            send_frame(tbl[v].bits, tbl[v].n);
            chk("busy_in_frame", busy, 1);
            finish_frame($sformatf("tbl%0d", v));
        end

        // Reset while the frame is emitting tail symbols
        ready_mode = 0;
        send_frame(16'b01, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_in_midrst", bus.o_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_valid", bus.o_valid, 0);
        chk("midrst_last", bus.o_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", cnt, 0);
        exp_cnt = 0;
        exp_q.delete();
        for (int j = 0; j < 6; j++) exp_q.push_back(tbl[0].syms[j]);
        send_frame(16'b1101, 4);
        chk("post_rst_cnt_pending", cnt, 0);
        finish_frame("post_rst");

        // Random frames against the reference model; FCNT_W=2 instance wraps along the way
        for (int f = 0; f < 20; f++) begin
            logic [15:0] bits = 16'($urandom);
            int n = $urandom_range(1, 12);
            ready_mode = (f % 3 == 0) ? 0 : 2;
            exp_q.delete();
            for (int j = 0; j < n + int'(K) - 1; j++) exp_q.push_back(model_sym(bits, n, j));
            send_frame(bits, n);
            finish_frame($sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
